// File: rtl/parking_pkg.sv
// Shared constants and saturating arithmetic helpers for the multi-class parking controller.
package parking_pkg;

  localparam int CLS_UNI       = 0;
  localparam int HOURS_PER_DAY = 24;

  // Class-select width; a single pool still gets a 1-bit select.
  function automatic int cls_width(input int num_class);
    return (num_class > 1) ? $clog2(num_class) : 1;
  endfunction

  function automatic int cls_gen(input int num_class);
    return num_class - 1;
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage

// File: rtl/parking_hour_clock.sv
// Hour-of-day clock: prescaler of TICKS_PER_HOUR cycles driving a 0..23 hour counter.
module parking_hour_clock import parking_pkg::*; #(
  parameter int HOUR_W         = 5,
  parameter int TICKS_PER_HOUR = 1,
  parameter int START_HOUR     = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [HOUR_W-1:0] t,
  output logic [HOUR_W-1:0] next_hour,
  output logic              hour_tick
);

  localparam int              PS_W      = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICKS_PER_HOUR - 1);
  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(HOURS_PER_DAY - 1);

  logic [PS_W-1:0] prescale;

  assign hour_tick = (prescale == PS_LAST);
  assign next_hour = (t == LAST_HOUR) ? '0 : t + HOUR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= '0;
      t        <= HOUR_W'(START_HOUR);
    end else begin
      prescale <= hour_tick ? '0 : prescale + PS_W'(1);
      if (hour_tick) t <= next_hour;
    end
  end

endmodule

// File: rtl/parking_multiclass_ctrl.sv
// Multi-class parking occupancy controller: per-pool counters, uni-to-general borrowing,
// and hourly capacity shifting from the uni pool to the general pool.
module parking_multiclass_ctrl import parking_pkg::*; #(
  parameter int                         NUM_CLASS      = 2,
  parameter int                         CNT_W          = 10,
  parameter logic [NUM_CLASS*CNT_W-1:0] CAP_INIT       = {10'd200, 10'd500},
  parameter int                         HOUR_W         = 5,
  parameter int                         TICKS_PER_HOUR = 1,
  parameter int                         START_HOUR     = 8,
  parameter int                         BORROW_EN      = 1,
  parameter int                         SHIFT_START    = 13,
  parameter int                         SHIFT_END      = 16,
  parameter int                         SHIFT_STEP     = 50,
  localparam int                        CLS_W          = cls_width(NUM_CLASS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       car_entered,
  input  logic [CLS_W-1:0]           entry_class,
  input  logic                       car_exited,
  input  logic [CLS_W-1:0]           exit_class,
  output logic                       entry_grant,
  output logic                       entry_deny,
  output logic                       exit_err,
  output logic [NUM_CLASS*CNT_W-1:0] parked_car,
  output logic [NUM_CLASS*CNT_W-1:0] vacated_space,
  output logic [NUM_CLASS-1:0]       is_vacated_space,
  output logic [CNT_W-1:0]           borrow_cnt,
  output logic [HOUR_W-1:0]          t
);

  localparam logic [CLS_W-1:0]  UNI_IDX  = CLS_W'(CLS_UNI);
  localparam logic [CLS_W-1:0]  GEN_IDX  = CLS_W'(cls_gen(NUM_CLASS));
  localparam logic [CNT_W-1:0]  STEP_C   = CNT_W'(SHIFT_STEP);
  localparam logic [31:0]       CNT_MAX  = (32'd1 << CNT_W) - 32'd1;
  localparam logic [HOUR_W-1:0] SH_START = HOUR_W'(SHIFT_START);
  localparam logic [HOUR_W-1:0] SH_END   = HOUR_W'(SHIFT_END);

  logic [CNT_W-1:0]  occ      [NUM_CLASS];
  logic [CNT_W-1:0]  occ_n    [NUM_CLASS];
  logic [CNT_W-1:0]  cap      [NUM_CLASS];
  logic [CNT_W-1:0]  cap_n    [NUM_CLASS];
  logic [CNT_W-1:0]  cap_init [NUM_CLASS];
  logic [CNT_W-1:0]  pool     [NUM_CLASS];
  logic [CNT_W-1:0]  borrow_n, step;
  logic [CNT_W:0]    gen_tot;
  logic              grant_n, deny_n, err_n, hour_tick;
  logic [HOUR_W-1:0] next_hour;

  parking_hour_clock #(
    .HOUR_W         (HOUR_W),
    .TICKS_PER_HOUR (TICKS_PER_HOUR),
    .START_HOUR     (START_HOUR)
  ) u_hour_clock (
    .clk       (clk),
    .rst       (rst),
    .t         (t),
    .next_hour (next_hour),
    .hour_tick (hour_tick)
  );

  // occ[GEN] holds only general-class cars; borrowed uni cars are added for reporting.
  always_comb begin
    pool          = occ;
    pool[GEN_IDX] = occ[GEN_IDX] + borrow_cnt;
  end

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_pool
    assign cap_init[g]                        = CAP_INIT[g*CNT_W +: CNT_W];
    assign parked_car[g*CNT_W +: CNT_W]       = pool[g];
    assign vacated_space[g*CNT_W +: CNT_W]    = CNT_W'(sat_sub(32'(cap[g]), 32'(pool[g])));
    assign is_vacated_space[g]                = |vacated_space[g*CNT_W +: CNT_W];
  end

  always_comb begin
    occ_n    = occ;
    cap_n    = cap;
    borrow_n = borrow_cnt;
    grant_n  = 1'b0;
    deny_n   = 1'b0;
    err_n    = 1'b0;
    step     = '0;

    // Exit is resolved first so a same-cycle entry sees the freed space.
    if (car_exited) begin
      if (int'(exit_class) >= NUM_CLASS)                    err_n = 1'b1;
      else if (exit_class == UNI_IDX && borrow_n != '0)     borrow_n = borrow_n - CNT_W'(1);
      else if (occ_n[exit_class] != '0)                     occ_n[exit_class] = occ_n[exit_class] - CNT_W'(1);
      else                                                  err_n = 1'b1;
    end

    gen_tot = {1'b0, occ_n[GEN_IDX]} + {1'b0, borrow_n};

    if (car_entered) begin
      if (int'(entry_class) >= NUM_CLASS) begin
        deny_n = 1'b1;
      end else if (entry_class == GEN_IDX) begin
        if (gen_tot < {1'b0, cap[GEN_IDX]}) begin
          occ_n[GEN_IDX] = occ_n[GEN_IDX] + CNT_W'(1);
          grant_n        = 1'b1;
        end else begin
          deny_n = 1'b1;
        end
      end else if (occ_n[entry_class] < cap[entry_class]) begin
        occ_n[entry_class] = occ_n[entry_class] + CNT_W'(1);
        grant_n            = 1'b1;
      end else if (entry_class == UNI_IDX && BORROW_EN != 0 && gen_tot < {1'b0, cap[GEN_IDX]}) begin
        borrow_n = borrow_n + CNT_W'(1);
        grant_n  = 1'b1;
      end else begin
        deny_n = 1'b1;
      end
    end

    if (hour_tick) begin
      if (next_hour == '0) begin
        cap_n = cap_init;
      end else if (next_hour >= SH_START && next_hour < SH_END) begin
        step           = (cap[UNI_IDX] < STEP_C) ? cap[UNI_IDX] : STEP_C;
        cap_n[UNI_IDX] = cap[UNI_IDX] - step;
        cap_n[GEN_IDX] = CNT_W'(sat_add(32'(cap[GEN_IDX]), 32'(step), CNT_MAX));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ         <= '{default: '0};
      cap         <= cap_init;
      borrow_cnt  <= '0;
      entry_grant <= 1'b0;
      entry_deny  <= 1'b0;
      exit_err    <= 1'b0;
    end else begin
      occ         <= occ_n;
      cap         <= cap_n;
      borrow_cnt  <= borrow_n;
      entry_grant <= grant_n;
      entry_deny  <= deny_n;
      exit_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_parking_multiclass_ctrl.sv
// Directed bench for parking_multiclass_ctrl: several parameterisations share one request
// bus; only the instance under test is out of reset at any time.
module tb_parking_multiclass_ctrl;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0;
  logic       car_entered = 1'b0, car_exited = 1'b0;
  logic [1:0] entry_class = 2'd0, exit_class = 2'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // A: defaults, slow hour clock.  B: slow clock, no borrowing.  C: defaults, 1 tick/hour.
  // D: capacities 2/2.  E: three classes.
  logic        grant_a, deny_a, err_a, grant_b, deny_b, err_b, grant_c, deny_c, err_c;
  logic        grant_d, deny_d, err_d, grant_e, deny_e, err_e;
  logic [19:0] parked_a, vac_a, parked_b, vac_b, parked_c, vac_c, parked_d, vac_d;
  logic [29:0] parked_e, vac_e;
  logic [1:0]  isv_a, isv_b, isv_c, isv_d;
  logic [2:0]  isv_e;
  logic [9:0]  borrow_a, borrow_b, borrow_c, borrow_d, borrow_e;
  logic [4:0]  t_a, t_b, t_c, t_d, t_e;

  parking_multiclass_ctrl #(.TICKS_PER_HOUR(1000)) dut_a (
    .clk(clk), .rst(rst_a), .car_entered(car_entered), .entry_class(entry_class[0]),
    .car_exited(car_exited), .exit_class(exit_class[0]), .entry_grant(grant_a),
    .entry_deny(deny_a), .exit_err(err_a), .parked_car(parked_a), .vacated_space(vac_a),
    .is_vacated_space(isv_a), .borrow_cnt(borrow_a), .t(t_a));

  parking_multiclass_ctrl #(.TICKS_PER_HOUR(100), .BORROW_EN(0)) dut_b (
    .clk(clk), .rst(rst_b), .car_entered(car_entered), .entry_class(entry_class[0]),
    .car_exited(car_exited), .exit_class(exit_class[0]), .entry_grant(grant_b),
    .entry_deny(deny_b), .exit_err(err_b), .parked_car(parked_b), .vacated_space(vac_b),
    .is_vacated_space(isv_b), .borrow_cnt(borrow_b), .t(t_b));

  parking_multiclass_ctrl dut_c (
    .clk(clk), .rst(rst_c), .car_entered(car_entered), .entry_class(entry_class[0]),
    .car_exited(car_exited), .exit_class(exit_class[0]), .entry_grant(grant_c),
    .entry_deny(deny_c), .exit_err(err_c), .parked_car(parked_c), .vacated_space(vac_c),
    .is_vacated_space(isv_c), .borrow_cnt(borrow_c), .t(t_c));

  parking_multiclass_ctrl #(.CAP_INIT({10'd2, 10'd2}), .TICKS_PER_HOUR(1000)) dut_d (
    .clk(clk), .rst(rst_d), .car_entered(car_entered), .entry_class(entry_class[0]),
    .car_exited(car_exited), .exit_class(exit_class[0]), .entry_grant(grant_d),
    .entry_deny(deny_d), .exit_err(err_d), .parked_car(parked_d), .vacated_space(vac_d),
    .is_vacated_space(isv_d), .borrow_cnt(borrow_d), .t(t_d));

  parking_multiclass_ctrl #(.NUM_CLASS(3), .CAP_INIT({10'd5, 10'd5, 10'd5}),
                            .TICKS_PER_HOUR(1000)) dut_e (
    .clk(clk), .rst(rst_e), .car_entered(car_entered), .entry_class(entry_class),
    .car_exited(car_exited), .exit_class(exit_class), .entry_grant(grant_e),
    .entry_deny(deny_e), .exit_err(err_e), .parked_car(parked_e), .vacated_space(vac_e),
    .is_vacated_space(isv_e), .borrow_cnt(borrow_e), .t(t_e));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // One request cycle: inputs sampled at the next edge, outputs read 1 time unit later.
  task automatic req(input logic e, input logic [1:0] ec, input logic x, input logic [1:0] xc);
    car_entered = e;
    entry_class = ec;
    car_exited  = x;
    exit_class  = xc;
    idle();
    car_entered = 1'b0;
    car_exited  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;

    // Reset values on the default configuration
    rst_a = 1'b1;
    idle();
    chk("a_reset_t", t_a, 32'd8);
    chk("a_reset_parked", parked_a, 32'd0);
    chk("a_reset_vac", vac_a, {10'd200, 10'd500});
    chk("a_reset_isv", isv_a, 32'b11);
    chk("a_reset_pulses", {grant_a, deny_a, err_a}, 32'd0);
    chk("a_reset_borrow", borrow_a, 32'd0);

    // Ten entries per class, one every two cycles
    for (int i = 0; i < 10; i++) begin
      req(1'b1, 2'd0, 1'b0, 2'd0);
      chk("a_uni_grant", grant_a, 32'd1);
      idle();
    end
    for (int i = 0; i < 10; i++) begin
      req(1'b1, 2'd1, 1'b0, 2'd0);
      chk("a_gen_grant", grant_a, 32'd1);
      idle();
    end
    chk("a_parked_10_10", parked_a, {10'd10, 10'd10});
    chk("a_vac_490_190", vac_a, {10'd190, 10'd490});
    chk("a_t_still_8", t_a, 32'd8);
    rst_a = 1'b0;

    // Borrowing with capacities 2/2
    rst_d = 1'b1;
    idle();
    req(1'b1, 2'd0, 1'b0, 2'd0);
    req(1'b1, 2'd0, 1'b0, 2'd0);
    chk("d_uni2_parked", parked_d, {10'd0, 10'd2});
    req(1'b1, 2'd0, 1'b0, 2'd0);
    chk("d_borrow1_grant", grant_d, 32'd1);
    chk("d_borrow1_cnt", borrow_d, 32'd1);
    chk("d_borrow1_parked", parked_d, {10'd1, 10'd2});
    chk("d_borrow1_isv", isv_d, 32'b10);
    req(1'b1, 2'd0, 1'b0, 2'd0);
    chk("d_borrow2_grant", grant_d, 32'd1);
    chk("d_borrow2_parked", parked_d, {10'd2, 10'd2});
    req(1'b1, 2'd0, 1'b0, 2'd0);
    chk("d_full_deny", {grant_d, deny_d}, 32'b01);
    chk("d_full_parked", parked_d, {10'd2, 10'd2});
    chk("d_full_isv", isv_d, 32'b00);
    req(1'b0, 2'd0, 1'b1, 2'd0);
    chk("d_exit1_borrow", borrow_d, 32'd1);
    chk("d_exit1_parked", parked_d, {10'd1, 10'd2});
    chk("d_exit1_err", err_d, 32'd0);
    req(1'b0, 2'd0, 1'b1, 2'd0);
    chk("d_exit2_borrow", borrow_d, 32'd0);
    chk("d_exit2_parked", parked_d, {10'd0, 10'd2});

    // Same-cycle exit and entry on a full general pool
    req(1'b1, 2'd1, 1'b0, 2'd0);
    req(1'b1, 2'd1, 1'b0, 2'd0);
    chk("d_gen_full_parked", parked_d, {10'd2, 10'd2});
    req(1'b1, 2'd1, 1'b1, 2'd1);
    chk("d_swap_grant", {grant_d, deny_d, err_d}, 32'b100);
    chk("d_swap_parked", parked_d, {10'd2, 10'd2});
    req(1'b1, 2'd1, 1'b0, 2'd0);
    chk("d_gen_full_deny", deny_d, 32'd1);
    req(1'b1, 2'd0, 1'b0, 2'd0);
    chk("d_no_borrow_space_deny", deny_d, 32'd1);
    chk("d_no_borrow_space_cnt", borrow_d, 32'd0);
    rst_d = 1'b0;

    // Empty-pool exits and out-of-range classes on a three-class lot
    rst_e = 1'b1;
    idle();
    req(1'b0, 2'd0, 1'b1, 2'd1);
    chk("e_exit_empty_err", err_e, 32'd1);
    chk("e_exit_empty_parked", parked_e, 32'd0);
    req(1'b0, 2'd0, 1'b1, 2'd0);
    chk("e_exit_uni_empty_err", err_e, 32'd1);
    req(1'b1, 2'd3, 1'b0, 2'd0);
    chk("e_bad_entry_deny", {grant_e, deny_e}, 32'b01);
    req(1'b0, 2'd0, 1'b1, 2'd3);
    chk("e_bad_exit_err", err_e, 32'd1);
    req(1'b1, 2'd2, 1'b0, 2'd0);
    chk("e_gen_grant", grant_e, 32'd1);
    chk("e_gen_parked", parked_e, {10'd1, 10'd0, 10'd0});
    req(1'b1, 2'd3, 1'b1, 2'd2);
    chk("e_mixed_pulses", {grant_e, deny_e, err_e}, 32'b010);
    chk("e_mixed_parked", parked_e, 32'd0);
    rst_e = 1'b0;

    // Capacity schedule with one cycle per hour
    rst_c = 1'b1;
    repeat (5) idle();
    chk("c_t13", t_c, 32'd13);
    chk("c_vac_t13", vac_c, {10'd250, 10'd450});
    idle();
    chk("c_vac_t14", vac_c, {10'd300, 10'd400});
    idle();
    chk("c_vac_t15", vac_c, {10'd350, 10'd350});
    idle();
    chk("c_vac_t16", vac_c, {10'd350, 10'd350});
    repeat (7) idle();
    chk("c_t23", t_c, 32'd23);
    chk("c_vac_t23", vac_c, {10'd350, 10'd350});
    idle();
    chk("c_t0", t_c, 32'd0);
    chk("c_vac_t0", vac_c, {10'd200, 10'd500});
    rst_c = 1'b0;

    // Capacity drops below occupancy: no eviction, entries refused
    rst_b = 1'b1;
    car_entered = 1'b1;
    entry_class = 2'd0;
    repeat (420) @(posedge clk);
    #1;
    car_entered = 1'b0;
    chk("b_parked_420", parked_b, {10'd0, 10'd420});
    for (int k = 0; k < 1000 && t_b != 5'd14; k++) idle();
    chk("b_reach_t14", t_b, 32'd14);
    chk("b_vac_t14", vac_b, {10'd300, 10'd0});
    chk("b_isv_t14", isv_b, 32'b10);
    req(1'b1, 2'd0, 1'b0, 2'd0);
    chk("b_over_cap_deny", {grant_b, deny_b}, 32'b01);
    chk("b_no_eviction", parked_b, {10'd0, 10'd420});
    req(1'b1, 2'd1, 1'b0, 2'd0);
    chk("b_gen_grant", grant_b, 32'd1);
    req(1'b0, 2'd0, 1'b1, 2'd0);
    chk("b_uni_exit", parked_b, {10'd1, 10'd419});
    chk("b_uni_exit_err", err_b, 32'd0);
    rst_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
